cam_entry_allocator: RTL
========================

# cam_entry_allocator

Storage and write side of a content-addressable memory. Holds SLOTS entries of VALUE_WIDTH bits with per-slot valid bits. Accepts insert requests (allocating the lowest free slot), removals by index, and a global flush. Drives the flattened value and valid arrays consumed by the CAM match/lookup logic, and provides a registered index-to-value read port, the inverse of the value-to-index lookup.

## Interface
- INDEX_WIDTH, 4, slot index width
- VALUE_WIDTH, 10, stored value width
- SLOTS, 1 << INDEX_WIDTH, number of slots; must be ≤ 2^INDEX_WIDTH and ≥ 1
- clock  input  1  rising-edge clock, single domain
- reset  input  1  asynchronous, active-high reset
- insert_valid  input  1  insert request
- insert_value  input  VALUE_WIDTH  value to store
- insert_ready  output  1  combinational: !full && !flush
- insert_done  output  1  registered one-cycle pulse, insert committed
- insert_index  output  INDEX_WIDTH  registered slot used by the committed insert
- remove_valid  input  1  invalidate slot remove_index
- remove_index  input  INDEX_WIDTH  slot to invalidate
- flush  input  1  invalidate all slots
- read_index  input  INDEX_WIDTH  slot to read
- read_value  output  VALUE_WIDTH  registered stored value of read_index
- read_valid  output  1  registered valid bit of read_index
- array_values  output  SLOTS*VALUE_WIDTH  slot i occupies bits [(i+1)*VALUE_WIDTH-1 -: VALUE_WIDTH], direct from storage registers
- array_valids  output  SLOTS  bit i = slot i valid, direct from registers
- occupancy  output  INDEX_WIDTH+1  registered count of valid slots
- full  output  1  occupancy == SLOTS
- empty  output  1  occupancy == 0

## Operation
- Reset (async, active-high): all values 0, all valids 0, occupancy 0, insert_done 0, insert_index 0, read_value 0, read_valid 0. After reset: empty=1, full=0, insert_ready=1.
- Insert accepted when insert_valid && insert_ready. Target slot: the lowest index whose valid bit is 0, taken from the current-cycle (pre-update) valids. On the next edge: value written, valid set, insert_done=1, insert_index=slot. insert_done is otherwise 0. insert_index holds its last value when insert_done=0.
- insert_valid while full or flush: ignored. No state change, no insert_done.
- Remove: when remove_valid is high and remove_index < SLOTS and the slot is valid, the valid bit is cleared on the next edge. Removing an invalid or out-of-range slot is a no-op. The stored value is retained; only the valid bit clears.
- Flush: all valids cleared and occupancy set to 0 on the next edge. Takes priority over same-cycle remove and insert (insert_ready is low, so no insert is accepted). Values are retained.
- Simultaneous insert and remove: both apply. Allocation uses pre-remove valids, so the slot being freed is never reused in the same cycle. Occupancy changes by +1 (insert only), -1 (effective remove only), or 0 (both).
- Occupancy arithmetic is INDEX_WIDTH+1 bits and never wraps: it cannot exceed SLOTS and cannot go below 0.
- Read: on each edge, read_value <= value[read_index] and read_valid <= valid[read_index], using pre-update state. For read_index ≥ SLOTS, both are 0.
- Slots at index ≥ SLOTS (non-power-of-two SLOTS) never exist and are never allocated.

## Timing
- insert_ready: combinational from full and flush. No dependency on insert_valid.
- Insert to array_valids/array_values visible: 1 cycle. insert_done coincides with visibility.
- Remove or flush to valid clear: 1 cycle.
- full, empty and occupancy are consistent with array_valids in the same cycle.
- Read latency: 1 cycle. A read of a slot being written in the same cycle returns the old contents.
- Back-to-back inserts at one per cycle until full. The insert in the cycle that fills the last slot is accepted, and insert_ready drops the following cycle.
- Reset asserted mid-operation: all state clears immediately. Any in-flight insert_done is lost.

## Test plan
- Reset, then 4 inserts (values 0x011, 0x022, 0x033, 0x044) on consecutive cycles -> insert_index 0, 1, 2, 3, each with an insert_done pulse; occupancy 4; array_valids = 0x000F.
- Fill all 16 slots, then assert insert_valid -> insert_ready=0, full=1, no insert_done, state unchanged. Remove slot 7, then insert 0x3FF -> insert_index 7, full=1 again.
- With slots 0-2 valid, remove slot 1 and insert 0x055 in the same cycle -> new value lands in slot 3 (not 1); occupancy stays 3; array_valids = 0x000D.
- Remove an already-invalid slot 9, and remove index 15 with SLOTS=12 -> no change to valids or occupancy.
- Flush with insert_valid and remove_valid also high -> next cycle array_valids=0, occupancy 0, empty=1, no insert_done; read of slot 0 returns read_valid=0 and the retained value 0x011.
- Assert reset asynchronously between edges while 5 slots are valid -> outputs clear without a clock edge; empty=1, insert_ready=1.

Source files
------------

// File: rtl/cam_entry_allocator.sv
// CAM storage and write side: lowest-free-slot insert, remove by index, flush,
// flattened value/valid arrays for the match logic and a registered index-to-value read port.
module cam_entry_allocator #(
    parameter int unsigned INDEX_WIDTH = 4,
    parameter int unsigned VALUE_WIDTH = 10,
    parameter int unsigned SLOTS       = 1 << INDEX_WIDTH
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         insert_valid,
    input  logic [VALUE_WIDTH-1:0]       insert_value,
    output logic                         insert_ready,
    output logic                         insert_done,
    output logic [INDEX_WIDTH-1:0]       insert_index,
    input  logic                         remove_valid,
    input  logic [INDEX_WIDTH-1:0]       remove_index,
    input  logic                         flush,
    input  logic [INDEX_WIDTH-1:0]       read_index,
    output logic [VALUE_WIDTH-1:0]       read_value,
    output logic                         read_valid,
    output logic [SLOTS*VALUE_WIDTH-1:0] array_values,
    output logic [SLOTS-1:0]             array_valids,
    output logic [INDEX_WIDTH:0]         occupancy,
    output logic                         full,
    output logic                         empty
);

    localparam logic [INDEX_WIDTH:0] SlotCount = (INDEX_WIDTH + 1)'(SLOTS);

    logic [VALUE_WIDTH-1:0] values_q [SLOTS];
    logic [VALUE_WIDTH-1:0] values_d [SLOTS];
    logic [SLOTS-1:0]       valids_q, valids_d;
    logic [INDEX_WIDTH:0]   occupancy_q, occupancy_d;
    logic                   insert_done_q, insert_done_d;
    logic [INDEX_WIDTH-1:0] insert_index_q, insert_index_d;
    logic [VALUE_WIDTH-1:0] read_value_q, read_value_d;
    logic                   read_valid_q, read_valid_d;

    logic                   alloc_found;
    logic [INDEX_WIDTH-1:0] alloc_index;
    logic [SLOTS-1:0]       alloc_onehot;
    logic [SLOTS-1:0]       remove_onehot;
    logic                   remove_hit;
    logic                   insert_fire;

    assign full         = (occupancy_q == SlotCount);
    assign empty        = (occupancy_q == '0);
    assign insert_ready = !full && !flush;
    assign insert_fire  = insert_valid && insert_ready && alloc_found;

    // Priority search over pre-update valids, so a slot freed this cycle is not reused.
    always_comb begin
        alloc_found  = 1'b0;
        alloc_index  = '0;
        alloc_onehot = '0;
        for (int unsigned i = 0; i < SLOTS; i++) begin
            if (!valids_q[i] && !alloc_found) begin
                alloc_found     = 1'b1;
                alloc_index     = INDEX_WIDTH'(i);
                alloc_onehot[i] = 1'b1;
            end
        end
    end

    // Out-of-range indices never match, which makes them a no-op.
    always_comb begin
        remove_onehot = '0;
        for (int unsigned i = 0; i < SLOTS; i++) begin
            if (remove_valid && (remove_index == INDEX_WIDTH'(i)) && valids_q[i]) begin
                remove_onehot[i] = 1'b1;
            end
        end
        remove_hit = |remove_onehot;
    end

    always_comb begin
        valids_d    = valids_q;
        values_d    = values_q;
        occupancy_d = occupancy_q;
        if (flush) begin
            valids_d    = '0;
            occupancy_d = '0;
        end else begin
            valids_d = (valids_q & ~remove_onehot) | (insert_fire ? alloc_onehot : '0);
            for (int unsigned i = 0; i < SLOTS; i++) begin
                if (insert_fire && alloc_onehot[i]) begin
                    values_d[i] = insert_value;
                end
            end
            case ({insert_fire, remove_hit})
                2'b10:   occupancy_d = occupancy_q + 1'b1;
                2'b01:   occupancy_d = occupancy_q - 1'b1;
                default: occupancy_d = occupancy_q;
            endcase
        end
    end

    always_comb begin
        insert_done_d  = insert_fire;
        insert_index_d = insert_fire ? alloc_index : insert_index_q;
        read_value_d   = '0;
        read_valid_d   = 1'b0;
        for (int unsigned i = 0; i < SLOTS; i++) begin
            if (read_index == INDEX_WIDTH'(i)) begin
                read_value_d = values_q[i];
                read_valid_d = valids_q[i];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < SLOTS; i++) begin
                values_q[i] <= '0;
            end
            valids_q       <= '0;
            occupancy_q    <= '0;
            insert_done_q  <= 1'b0;
            insert_index_q <= '0;
            read_value_q   <= '0;
            read_valid_q   <= 1'b0;
        end else begin
            values_q       <= values_d;
            valids_q       <= valids_d;
            occupancy_q    <= occupancy_d;
            insert_done_q  <= insert_done_d;
            insert_index_q <= insert_index_d;
            read_value_q   <= read_value_d;
            read_valid_q   <= read_valid_d;
        end
    end

    always_comb begin
        array_values = '0;
        for (int unsigned i = 0; i < SLOTS; i++) begin
            array_values[i*VALUE_WIDTH +: VALUE_WIDTH] = values_q[i];
        end
    end

    assign array_valids = valids_q;
    assign occupancy    = occupancy_q;
    assign insert_done  = insert_done_q;
    assign insert_index = insert_index_q;
    assign read_value   = read_value_q;
    assign read_valid   = read_valid_q;

endmodule
